// File: rtl/caxi4interconnect_dwc_downconv_bchannel.sv
// ---------------------------------------------------------------------------
// caxi4interconnect_dwc_downconv_bchannel
//
// Write-response (B) channel of the AXI4 data-width down converter. A master
// write that was split into N narrower slave writes returns N slave B
// responses. This block merges them into one master B response. The AW path
// pushes {ID, N-1} into a small command FIFO for each master write, and
// groups are merged in FIFO order.
//
// Ports
//   ACLK, sysReset          clock and asynchronous active-low reset
//   MASTER_B*               merged response to the wide-side master (registered)
//   SLAVE_B*                per-split responses from the narrow-side slave
//   bchan_cmd_fifo_full     asserted when at most one free FIFO slot remains
//   wr_en_cmd               push strobe for a command entry
//   BRespFifoWrData         command entry {ID, N-1}
// ---------------------------------------------------------------------------
module caxi4interconnect_dwc_downconv_bchannel #(
    parameter int ID_WIDTH        = 1,
    parameter int USER_WIDTH      = 1,
    parameter int ADDR_FIFO_DEPTH = 3,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                          ACLK,
    input  logic                          sysReset,
    output logic [ID_WIDTH-1:0]           MASTER_BID,
    output logic [1:0]                    MASTER_BRESP,
    output logic [USER_WIDTH-1:0]         MASTER_BUSER,
    output logic                          MASTER_BVALID,
    input  logic                          MASTER_BREADY,
    input  logic [ID_WIDTH-1:0]           SLAVE_BID,
    input  logic [1:0]                    SLAVE_BRESP,
    input  logic [USER_WIDTH-1:0]         SLAVE_BUSER,
    input  logic                          SLAVE_BVALID,
    output logic                          SLAVE_BREADY,
    output logic                          bchan_cmd_fifo_full,
    input  logic                          wr_en_cmd,
    input  logic [ID_WIDTH+CNT_WIDTH-1:0] BRespFifoWrData
);

    localparam int ENTRY_W = ID_WIDTH + CNT_WIDTH;
    localparam int PTR_W   = $clog2(ADDR_FIFO_DEPTH);
    localparam int CNTF_W  = $clog2(ADDR_FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(ADDR_FIFO_DEPTH - 1);
    localparam logic [CNTF_W-1:0] DEPTH_C  = CNTF_W'(ADDR_FIFO_DEPTH);
    localparam logic [CNTF_W-1:0] FULL_C   = CNTF_W'(ADDR_FIFO_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_RESP    = 1'b1
    } state_t;

    // AXI response codes are ordered by severity, so the merge is an unsigned max.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [ENTRY_W-1:0]    mem_r [ADDR_FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNTF_W-1:0]     count_r;
    logic [CNTF_W-1:0]     count_next_s;
    logic                  full_r;
    logic                  fifo_empty_s;
    logic                  push_s;
    logic                  pop_s;
    logic [ENTRY_W-1:0]    head_s;
    logic [ID_WIDTH-1:0]   head_id_s;
    logic [CNT_WIDTH-1:0]  head_cnt_s;

    state_t                state_r;
    state_t                state_next_s;
    logic                  slave_bready_s;
    logic                  slave_hs_s;
    logic                  last_beat_s;
    logic [1:0]            acc_next_s;
    logic [CNT_WIDTH-1:0]  beat_cnt_r;
    logic [1:0]            acc_r;

    logic [ID_WIDTH-1:0]   master_bid_r;
    logic [1:0]            master_bresp_r;
    logic [USER_WIDTH-1:0] master_buser_r;
    logic                  master_bvalid_r;

    // The slave ID is not used for routing; groups are tracked purely by FIFO order.
    logic                  unused_s;
    assign unused_s = ^{SLAVE_BID, 1'b0};

    assign fifo_empty_s = (count_r == {CNTF_W{1'b0}});
    assign head_s       = mem_r[rd_ptr_r];
    assign head_id_s    = head_s[ENTRY_W-1:CNT_WIDTH];
    assign head_cnt_s   = head_s[CNT_WIDTH-1:0];
    // A push while full is only legal when the head is leaving in the same cycle.
    assign push_s       = wr_en_cmd && ((count_r != DEPTH_C) || pop_s);

    // FIFO occupancy next-value
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNTF_W'(1);
            2'b01:   count_next_s = count_r - CNTF_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Command FIFO storage, pointers, occupancy and registered full flag
    always_ff @(posedge ACLK or negedge sysReset) begin
        if (!sysReset) begin
            for (int i = 0; i < ADDR_FIFO_DEPTH; i++) begin
                mem_r[i] <= {ENTRY_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNTF_W{1'b0}};
            full_r   <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= BRespFifoWrData;
                wr_ptr_r        <= (wr_ptr_r == LAST_PTR) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s >= FULL_C);
        end
    end

    // Merge datapath helpers
    always_comb begin
        slave_hs_s  = SLAVE_BVALID && slave_bready_s;
        last_beat_s = (beat_cnt_r == head_cnt_s);
        acc_next_s  = resp_max(acc_r, SLAVE_BRESP);
    end

    // FSM next-state, slave ready and FIFO pop
    always_comb begin
        state_next_s   = state_r;
        slave_bready_s = 1'b0;
        pop_s          = 1'b0;
        case (state_r)
            ST_COLLECT: begin
                slave_bready_s = !fifo_empty_s;
                if (SLAVE_BVALID && !fifo_empty_s && (beat_cnt_r == head_cnt_s)) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_COLLECT;
                end
            end
            ST_RESP: begin
                if (master_bvalid_r && MASTER_BREADY) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_COLLECT;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_COLLECT;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge ACLK or negedge sysReset) begin
        if (!sysReset) begin
            state_r <= ST_COLLECT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Beat counting, response accumulation and registered master outputs
    always_ff @(posedge ACLK or negedge sysReset) begin
        if (!sysReset) begin
            beat_cnt_r      <= {CNT_WIDTH{1'b0}};
            acc_r           <= 2'b00;
            master_bid_r    <= {ID_WIDTH{1'b0}};
            master_bresp_r  <= 2'b00;
            master_buser_r  <= {USER_WIDTH{1'b0}};
            master_bvalid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_COLLECT: begin
                    if (slave_hs_s) begin
                        if (last_beat_s) begin
                            master_bresp_r  <= acc_next_s;
                            master_buser_r  <= SLAVE_BUSER;
                            master_bid_r    <= head_id_s;
                            master_bvalid_r <= 1'b1;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + CNT_WIDTH'(1);
                            acc_r      <= acc_next_s;
                        end
                    end
                end
                ST_RESP: begin
                    if (pop_s) begin
                        master_bvalid_r <= 1'b0;
                        beat_cnt_r      <= {CNT_WIDTH{1'b0}};
                        acc_r           <= 2'b00;
                    end
                end
                default: begin
                    master_bvalid_r <= 1'b0;
                end
            endcase
        end
    end

    assign MASTER_BID          = master_bid_r;
    assign MASTER_BRESP        = master_bresp_r;
    assign MASTER_BUSER        = master_buser_r;
    assign MASTER_BVALID       = master_bvalid_r;
    assign SLAVE_BREADY        = slave_bready_s;
    assign bchan_cmd_fifo_full = full_r;

endmodule

// File: tb/tb_caxi4interconnect_dwc_downconv_bchannel.sv
// ---------------------------------------------------------------------------
// Testbench for caxi4interconnect_dwc_downconv_bchannel. Directed groups push
// their hand-computed merged response into a scoreboard queue; a monitor pops
// and compares whenever a master B handshake is about to occur.
// ---------------------------------------------------------------------------
module tb_caxi4interconnect_dwc_downconv_bchannel;

    localparam int IDW  = 4;
    localparam int UW   = 2;
    localparam int DEP  = 3;
    localparam int CNTW = 8;

    typedef struct {
        logic [IDW-1:0] id;
        logic [1:0]     resp;
        logic [UW-1:0]  user;
    } exp_t;

    logic                 ACLK;
    logic                 sysReset;
    logic [IDW-1:0]       MASTER_BID;
    logic [1:0]           MASTER_BRESP;
    logic [UW-1:0]        MASTER_BUSER;
    logic                 MASTER_BVALID;
    logic                 MASTER_BREADY;
    logic [IDW-1:0]       SLAVE_BID;
    logic [1:0]           SLAVE_BRESP;
    logic [UW-1:0]        SLAVE_BUSER;
    logic                 SLAVE_BVALID;
    logic                 SLAVE_BREADY;
    logic                 bchan_cmd_fifo_full;
    logic                 wr_en_cmd;
    logic [IDW+CNTW-1:0]  BRespFifoWrData;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    caxi4interconnect_dwc_downconv_bchannel #(
        .ID_WIDTH        (IDW),
        .USER_WIDTH      (UW),
        .ADDR_FIFO_DEPTH (DEP),
        .CNT_WIDTH       (CNTW)
    ) dut (
        .ACLK                (ACLK),
        .sysReset            (sysReset),
        .MASTER_BID          (MASTER_BID),
        .MASTER_BRESP        (MASTER_BRESP),
        .MASTER_BUSER        (MASTER_BUSER),
        .MASTER_BVALID       (MASTER_BVALID),
        .MASTER_BREADY       (MASTER_BREADY),
        .SLAVE_BID           (SLAVE_BID),
        .SLAVE_BRESP         (SLAVE_BRESP),
        .SLAVE_BUSER         (SLAVE_BUSER),
        .SLAVE_BVALID        (SLAVE_BVALID),
        .SLAVE_BREADY        (SLAVE_BREADY),
        .bchan_cmd_fifo_full (bchan_cmd_fifo_full),
        .wr_en_cmd           (wr_en_cmd),
        .BRespFifoWrData     (BRespFifoWrData)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake completes at the next rising edge, so compare once here.
    always @(negedge ACLK) begin
        if (sysReset && MASTER_BVALID && MASTER_BREADY) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_bresp: got id=%0h resp=%0h user=%0h with empty scoreboard",
                         MASTER_BID, MASTER_BRESP, MASTER_BUSER);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (MASTER_BID !== e.id || MASTER_BRESP !== e.resp || MASTER_BUSER !== e.user) begin
                    n_fail++;
                    $display("FAIL master_b: got id=%0h resp=%0h user=%0h expected id=%0h resp=%0h user=%0h",
                             MASTER_BID, MASTER_BRESP, MASTER_BUSER, e.id, e.resp, e.user);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the next rising edge.
    task automatic push_cmd(input logic [IDW-1:0] id, input logic [CNTW-1:0] n1);
        wr_en_cmd       = 1'b1;
        BRespFifoWrData = {id, n1};
        @(posedge ACLK);
        #1;
        wr_en_cmd       = 1'b0;
    endtask

    task automatic expect_b(input logic [IDW-1:0] id, input logic [1:0] resp, input logic [UW-1:0] user);
        exp_t e;
        e.id   = id;
        e.resp = resp;
        e.user = user;
        sb_q.push_back(e);
    endtask

    task automatic slave_beat(input logic [1:0] resp, input logic [UW-1:0] user);
        bit ok;
        ok           = 1'b0;
        SLAVE_BVALID = 1'b1;
        SLAVE_BRESP  = resp;
        SLAVE_BUSER  = user;
        SLAVE_BID    = 4'hF;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (SLAVE_BREADY) begin
                ok = 1'b1;
                @(posedge ACLK);
                #1;
                break;
            end
        end
        SLAVE_BVALID = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL slave_handshake_timeout: got no SLAVE_BREADY expected handshake");
        end
    endtask

    task automatic wait_empty(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge ACLK);
            #2;
            if (sb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        sysReset        = 1'b0;
        MASTER_BREADY   = 1'b1;
        SLAVE_BID       = 4'h0;
        SLAVE_BRESP     = 2'b00;
        SLAVE_BUSER     = 2'b00;
        SLAVE_BVALID    = 1'b0;
        wr_en_cmd       = 1'b0;
        BRespFifoWrData = 12'h000;

        // Reset state
        repeat (2) @(negedge ACLK);
        check("rst_bvalid", {31'd0, MASTER_BVALID}, 32'd0);
        check("rst_sready", {31'd0, SLAVE_BREADY}, 32'd0);
        check("rst_full", {31'd0, bchan_cmd_fifo_full}, 32'd0);
        check("rst_bid_resp_user", {24'd0, MASTER_BID, MASTER_BRESP, MASTER_BUSER}, 32'd0);
        sysReset = 1'b1;
        @(posedge ACLK);
        #1;

        // 1: single beat passes through, BVALID one cycle after the handshake
        push_cmd(4'd3, 8'd0);
        expect_b(4'd3, 2'b01, 2'd2);
        slave_beat(2'b01, 2'd2);
        check("t1_latency", {31'd0, MASTER_BVALID}, 32'd1);
        wait_empty("t1_drain");

        // 2: four beats merged to SLVERR, BUSER from the last beat
        push_cmd(4'd5, 8'd3);
        expect_b(4'd5, 2'b10, 2'd1);
        slave_beat(2'b00, 2'd1);
        check("t2_bvalid_beat1", {31'd0, MASTER_BVALID}, 32'd0);
        slave_beat(2'b10, 2'd2);
        check("t2_bvalid_beat2", {31'd0, MASTER_BVALID}, 32'd0);
        slave_beat(2'b00, 2'd3);
        check("t2_bvalid_beat3", {31'd0, MASTER_BVALID}, 32'd0);
        slave_beat(2'b00, 2'd1);
        check("t2_bvalid_beat4", {31'd0, MASTER_BVALID}, 32'd1);
        wait_empty("t2_drain");

        // 3: master back-pressure holds the response and blocks the slave side
        MASTER_BREADY = 1'b0;
        push_cmd(4'd6, 8'd1);
        expect_b(4'd6, 2'b01, 2'd0);
        slave_beat(2'b01, 2'd3);
        slave_beat(2'b00, 2'd0);
        SLAVE_BVALID = 1'b1;
        SLAVE_BRESP  = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("t3_hold", {27'd0, MASTER_BVALID, MASTER_BID, MASTER_BRESP, SLAVE_BREADY},
                  {27'd0, 1'b1, 4'd6, 2'b01, 1'b0});
        end
        @(posedge ACLK);
        #1;
        SLAVE_BVALID  = 1'b0;
        MASTER_BREADY = 1'b1;
        wait_empty("t3_drain");

        // 4: full flag at DEPTH-1 entries, push and pop in the same cycle
        MASTER_BREADY = 1'b0;
        push_cmd(4'd1, 8'd0);
        check("t4_full_one", {31'd0, bchan_cmd_fifo_full}, 32'd0);
        push_cmd(4'd2, 8'd0);
        check("t4_full_two", {31'd0, bchan_cmd_fifo_full}, 32'd1);
        expect_b(4'd1, 2'b00, 2'd1);
        expect_b(4'd2, 2'b00, 2'd2);
        expect_b(4'd4, 2'b11, 2'd3);
        slave_beat(2'b00, 2'd1);
        wr_en_cmd       = 1'b1;
        BRespFifoWrData = {4'd4, 8'd0};
        MASTER_BREADY   = 1'b1;
        @(posedge ACLK);
        #1;
        wr_en_cmd = 1'b0;
        check("t4_full_pushpop", {31'd0, bchan_cmd_fifo_full}, 32'd1);
        slave_beat(2'b00, 2'd2);
        slave_beat(2'b11, 2'd3);
        wait_empty("t4_drain");
        check("t4_full_empty", {31'd0, bchan_cmd_fifo_full}, 32'd0);

        // 5: reset in the middle of an 8-beat group discards it
        push_cmd(4'd7, 8'd7);
        for (int i = 0; i < 4; i++) begin
            slave_beat(2'b10, 2'd3);
        end
        #2;
        sysReset = 1'b0;
        #1;
        check("t5_rst_outputs", {22'd0, MASTER_BVALID, MASTER_BID, MASTER_BRESP, MASTER_BUSER, SLAVE_BREADY},
              32'd0);
        check("t5_rst_full", {31'd0, bchan_cmd_fifo_full}, 32'd0);
        @(negedge ACLK);
        sysReset = 1'b1;
        @(posedge ACLK);
        #1;
        push_cmd(4'd9, 8'd1);
        expect_b(4'd9, 2'b01, 2'd1);
        slave_beat(2'b00, 2'd3);
        slave_beat(2'b01, 2'd1);
        wait_empty("t5_drain");

        // 6: DECERR dominates a later OKAY-class beat; no acceptance with empty FIFO
        push_cmd(4'd2, 8'd1);
        expect_b(4'd2, 2'b11, 2'd2);
        slave_beat(2'b11, 2'd0);
        slave_beat(2'b01, 2'd2);
        wait_empty("t6_drain");
        SLAVE_BVALID = 1'b1;
        SLAVE_BRESP  = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check("t6_sready_empty", {31'd0, SLAVE_BREADY}, 32'd0);
        end
        @(posedge ACLK);
        #1;
        SLAVE_BVALID = 1'b0;
        repeat (3) @(posedge ACLK);
        check("final_scoreboard_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
